// File: rtl/sprite_rom_fetch_if.sv
// Sprite ROM fetch bundle: sprite-generator address side, memory request/ack port and planar output.
interface sprite_rom_fetch_if #(
    parameter int AW    = 19,
    parameter int CNT_W = 16
);
    logic [17:0]      ca;
    logic             bank;
    logic [2:0]       dec_sel;
    logic [AW-1:0]    mem_addr;
    logic             mem_req;
    logic             mem_ack;
    logic [31:0]      mem_data;
    logic [31:0]      cd;
    logic             cd_valid;
    logic [CNT_W-1:0] late_cnt;

    modport slave (
        input  ca, bank, dec_sel, mem_ack, mem_data,
        output mem_addr, mem_req, cd, cd_valid, late_cnt
    );

    modport master (
        output ca, bank, dec_sel, mem_ack, mem_data,
        input  mem_addr, mem_req, cd, cd_valid, late_cnt
    );
endinterface

// File: rtl/sprite_rom_fetch.sv
// Serves the sprite ROM address stream from a req/ack memory port and returns planar words.
// Optional next-word prefetch buffer is built when SPR_PREFETCH_EN is defined.
module sprite_rom_fetch #(
    parameter int AW    = 19,
    parameter int CNT_W = 16
) (
    input  logic               clk_main,
    input  logic               reset,
    sprite_rom_fetch_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
`ifdef SPR_PREFETCH_EN
    localparam logic [1:0] ST_PF   = 2'd2;
`endif

    function automatic logic [31:0] planar(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 8; i++)
                r[8*p+i] = w[4*i+p];
        return r;
    endfunction

    logic [8:0]       dec;
    logic [AW-1:0]    a_d, a_q;
    logic [1:0]       state_d, state_q;
    logic             req_d, req_q;
    logic [AW-1:0]    addr_d, addr_q;
    logic [31:0]      cd_d, cd_q;
    logic [AW-1:0]    tag_d, tag_q;
    logic             tag_v_d, tag_v_q;
    logic             cd_valid_d, cd_valid_q;
    logic [CNT_W-1:0] late_d, late_q;
    logic             miss;
`ifdef SPR_PREFETCH_EN
    logic [31:0]      pb_d, pb_q;
    logic [AW-1:0]    pb_tag_d, pb_tag_q;
    logic             pb_v_d, pb_v_q;
`endif

    // Address-line scramble per bank, chosen by the decode PROM; ca[3] always rides in bit 0.
    always_comb begin
        dec = '0;
        case (bus.dec_sel)
            3'd0:       dec = {bus.ca[9], bus.ca[8], bus.ca[7], bus.ca[6], bus.ca[5], bus.ca[4], bus.ca[2], bus.ca[1], bus.ca[0]};
            3'd1:       dec = {bus.ca[9], bus.ca[8], bus.ca[7], bus.ca[5], bus.ca[6], bus.ca[4], bus.ca[2], bus.ca[1], bus.ca[0]};
            3'd2, 3'd3: dec = {bus.ca[9], bus.ca[8], bus.ca[7], bus.ca[6], bus.ca[4], bus.ca[2], bus.ca[1], bus.ca[0], bus.ca[5]};
            3'd4:       dec = {bus.ca[9], bus.ca[7], bus.ca[8], bus.ca[6], bus.ca[4], bus.ca[2], bus.ca[1], bus.ca[0], bus.ca[5]};
            3'd5, 3'd6: dec = {bus.ca[9], bus.ca[8], bus.ca[6], bus.ca[4], bus.ca[2], bus.ca[1], bus.ca[0], bus.ca[7], bus.ca[5]};
            default:    dec = {bus.ca[8], bus.ca[6], bus.ca[4], bus.ca[2], bus.ca[1], bus.ca[0], bus.ca[9], bus.ca[7], bus.ca[5]};
        endcase
        a_d = {bus.bank, bus.ca[17:10], dec, bus.ca[3]};
    end

    assign miss = !tag_v_q || (a_q != tag_q);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        cd_d    = cd_q;
        tag_d   = tag_q;
        tag_v_d = tag_v_q;
        late_d  = late_q;
`ifdef SPR_PREFETCH_EN
        pb_d     = pb_q;
        pb_tag_d = pb_tag_q;
        pb_v_d   = pb_v_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef SPR_PREFETCH_EN
                if (miss && pb_v_q && (a_q == pb_tag_q)) begin
                    cd_d    = pb_q;
                    tag_d   = pb_tag_q;
                    tag_v_d = 1'b1;
                end else if (miss) begin
                    req_d   = 1'b1;
                    addr_d  = a_q;
                    state_d = ST_WAIT;
                end else if (cd_valid_q && !(pb_v_q && (pb_tag_q == tag_q + 1'b1))) begin
                    req_d   = 1'b1;
                    addr_d  = tag_q + 1'b1;
                    state_d = ST_PF;
                end
`else
                if (miss) begin
                    req_d   = 1'b1;
                    addr_d  = a_q;
                    state_d = ST_WAIT;
                end
`endif
            end
`ifdef SPR_PREFETCH_EN
            // A demand miss seen here is picked up from IDLE once the prefetch lands.
            ST_PF: begin
                if (bus.mem_ack) begin
                    pb_d     = planar(bus.mem_data);
                    pb_tag_d = addr_q;
                    pb_v_d   = 1'b1;
                    req_d    = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
`endif
            default: begin
                if (bus.mem_ack) begin
                    cd_d    = planar(bus.mem_data);
                    tag_d   = addr_q;
                    tag_v_d = 1'b1;
                    if (a_q == addr_q) begin
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        // Superseded: chain straight into the new address, request stays up.
                        addr_d = a_q;
                        if (late_q != '1)
                            late_d = late_q + 1'b1;
                    end
                end
            end
        endcase
        cd_valid_d = tag_v_d && (tag_d == a_q);
    end

    // Input pipeline is not reset so the first post-reset decision already sees live ca.
    always_ff @(posedge clk_main) begin
        a_q <= a_d;
    end

    always_ff @(posedge clk_main) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            cd_q       <= '0;
            tag_q      <= '0;
            tag_v_q    <= 1'b0;
            cd_valid_q <= 1'b0;
            late_q     <= '0;
`ifdef SPR_PREFETCH_EN
            pb_q       <= '0;
            pb_tag_q   <= '0;
            pb_v_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            cd_q       <= cd_d;
            tag_q      <= tag_d;
            tag_v_q    <= tag_v_d;
            cd_valid_q <= cd_valid_d;
            late_q     <= late_d;
`ifdef SPR_PREFETCH_EN
            pb_q       <= pb_d;
            pb_tag_q   <= pb_tag_d;
            pb_v_q     <= pb_v_d;
`endif
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_req  = req_q;
    assign bus.cd       = cd_q;
    assign bus.cd_valid = cd_valid_q;
    assign bus.late_cnt = late_q;
endmodule

// File: tb/tb_sprite_rom_fetch.sv
// Bench for sprite_rom_fetch: directed vector table, corner sequences and randomized traffic vs a reference model.
module tb_sprite_rom_fetch;
    logic clk_main = 1'b0;
    logic reset;
    always #5 clk_main = ~clk_main;

    sprite_rom_fetch_if #(.AW(19), .CNT_W(16)) bus();
    sprite_rom_fetch #(.AW(19), .CNT_W(16)) dut (.clk_main(clk_main), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: word address from the decode table (source ca bit per position, MSB first).
    function automatic logic [18:0] map_addr(input logic [17:0] ca, input logic b, input logic [2:0] s);
        int order [9];
        logic [8:0] d;
        case (s)
            3'd0:       order = '{9, 8, 7, 6, 5, 4, 2, 1, 0};
            3'd1:       order = '{9, 8, 7, 5, 6, 4, 2, 1, 0};
            3'd2, 3'd3: order = '{9, 8, 7, 6, 4, 2, 1, 0, 5};
            3'd4:       order = '{9, 7, 8, 6, 4, 2, 1, 0, 5};
            3'd5, 3'd6: order = '{9, 8, 6, 4, 2, 1, 0, 7, 5};
            default:    order = '{8, 6, 4, 2, 1, 0, 9, 7, 5};
        endcase
        for (int k = 0; k < 9; k++) d[8-k] = ca[order[k]];
        return {b, ca[17:10], d, ca[3]};
    endfunction

    function automatic logic [31:0] planar(input logic [31:0] w);
        logic [31:0] r;
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 8; i++)
                r[8*p+i] = w[4*i+p];
        return r;
    endfunction

    logic [31:0] ovr [logic [18:0]];
    function automatic logic [31:0] rom(input logic [18:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    // Memory model: acks each request ack_delay cycles after it first appears.
    int          ack_delay = 3;
    bit          busy = 0;
    int          cnt = 0;
    logic [18:0] cur = '0;
    int          reqs = 0;
    int          unstable = 0;
    bit          stray = 0;
    initial begin
        bus.mem_ack  = 1'b0;
        bus.mem_data = '0;
    end
    always @(negedge clk_main) begin
        if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            busy = 0;
        end
        if (bus.mem_req) begin
            if (!busy) begin
                busy = 1; cnt = 0; cur = bus.mem_addr; reqs++;
            end else if (bus.mem_addr != cur) begin
                unstable++;
            end
            cnt++;
            if (cnt >= ack_delay) begin
                bus.mem_ack  = 1'b1;
                bus.mem_data = rom(cur);
            end
        end else begin
            busy = 0;
            if (stray) begin
                bus.mem_ack  = 1'b1;
                bus.mem_data = 32'hDEADBEEF;
                stray = 0;
            end
        end
    end

    // Whenever cd_valid is up, cd must be the planar word for the address sampled two edges back.
    logic [18:0] hist0 = '0, hist1 = '0;
    always @(posedge clk_main) begin
        hist1 = hist0;
        hist0 = map_addr(bus.ca, bus.bank, bus.dec_sel);
    end
    always @(negedge clk_main) begin
        if (!reset && bus.cd_valid === 1'b1)
            chk("cd_vs_addr", bus.cd, planar(rom(hist1)));
    end

    task automatic wait_valid(input int lim);
        int k = 0;
        while (bus.cd_valid !== 1'b1 && k < lim) begin
            @(negedge clk_main);
            k++;
        end
        chk("valid_timeout", bus.cd_valid, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},   bus.mem_req,  0);
        chk({tag, "_addr"},  bus.mem_addr, 0);
        chk({tag, "_cd"},    bus.cd,       0);
        chk({tag, "_valid"}, bus.cd_valid, 0);
        chk({tag, "_late"},  bus.late_cnt, 0);
    endtask

    task automatic drive(input logic [17:0] ca, input logic b, input logic [2:0] s);
        bus.ca = ca; bus.bank = b; bus.dec_sel = s;
    endtask

    typedef struct {
        logic [17:0] ca;
        logic        bank;
        logic [2:0]  dec;
        logic [31:0] data;
        logic [18:0] exp_addr;
        logic [31:0] exp_cd;
    } vec_t;
    localparam int NV = 11;
    vec_t vt [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, l0, all_v;
        logic [31:0] cd0;
        logic [17:0] rca;
        logic        rb;
        logic [2:0]  rs;

        vt[0]  = '{18'h00400, 1'b0, 3'd0, 32'h00000001, 19'h00400, 32'h00000001};
        vt[1]  = '{18'h00220, 1'b0, 3'd7, 32'h80000000, 19'h0000A, 32'h80000000};
        vt[2]  = '{18'h00220, 1'b0, 3'd1, 32'h00000010, 19'h00240, 32'h00000002};
        vt[3]  = '{18'h3FFFF, 1'b1, 3'd0, 32'hFFFFFFFF, 19'h7FFFF, 32'hFFFFFFFF};
        vt[4]  = '{18'h00008, 1'b0, 3'd2, 32'h0000000F, 19'h00001, 32'h01010101};
        vt[5]  = '{18'h00020, 1'b0, 3'd2, 32'h11111111, 19'h00002, 32'h000000FF};
        vt[6]  = '{18'h00080, 1'b0, 3'd4, 32'hF0000000, 19'h00100, 32'h80808080};
        vt[7]  = '{18'h00080, 1'b0, 3'd5, 32'h00000002, 19'h00004, 32'h00000100};
        vt[8]  = '{18'h00040, 1'b0, 3'd6, 32'h00000100, 19'h00080, 32'h00000004};
        vt[9]  = '{18'h00010, 1'b0, 3'd3, 32'h00000020, 19'h00020, 32'h00000200};
        vt[10] = '{18'h20200, 1'b1, 3'd7, 32'h00000000, 19'h60008, 32'h00000000};

        reset = 1'b1;
        drive(vt[0].ca, vt[0].bank, vt[0].dec);
        repeat (3) @(negedge clk_main);
        chk_zero("rst");

        for (int i = 0; i < NV; i++) begin
            r0 = reqs;
            ovr[vt[i].exp_addr] = vt[i].data;
            drive(vt[i].ca, vt[i].bank, vt[i].dec);
            reset = 1'b0;
            repeat (2) @(negedge clk_main);
            chk("vec_req", bus.mem_req, 1);
            chk("vec_addr", bus.mem_addr, vt[i].exp_addr);
            chk("vec_drop", bus.cd_valid, 0);
            wait_valid(40);
            chk("vec_cd", bus.cd, vt[i].exp_cd);
            chk("vec_nreq", reqs - r0, 1);
        end

        // Address change while the first request is still outstanding.
        ack_delay = 6;
        r0 = reqs; l0 = bus.late_cnt;
        drive(18'h01230, 1'b0, 3'd0);
        repeat (4) @(negedge clk_main);
        drive(18'h01240, 1'b0, 3'd0);
        wait_valid(60);
        chk("late_cd", bus.cd, planar(rom(map_addr(18'h01240, 1'b0, 3'd0))));
        chk("late_cnt", bus.late_cnt, l0 + 1);
        chk("late_nreq", reqs - r0, 2);
        chk("req_stable", unstable, 0);

        // Held address: no traffic, output stays put; a stray ack in IDLE is ignored.
        ack_delay = 3;
        r0 = reqs; cd0 = bus.cd; all_v = 1;
        repeat (20) begin
            @(negedge clk_main);
            if (bus.cd_valid !== 1'b1) all_v = 0;
        end
        chk("hold_nreq", reqs - r0, 0);
        chk("hold_valid", all_v, 1);
        stray = 1;
        repeat (3) @(negedge clk_main);
        chk("stray_cd", bus.cd, cd0);
        chk("stray_valid", bus.cd_valid, 1);
        chk("stray_nreq", reqs - r0, 0);

        // Reset in the middle of a wait.
        ack_delay = 6;
        drive(18'h05555, 1'b1, 3'd4);
        repeat (3) @(negedge clk_main);
        chk("mid_req", bus.mem_req, 1);
        reset = 1'b1;
        @(negedge clk_main);
        chk_zero("midrst");
        reset = 1'b0;
        ack_delay = 3;
        wait_valid(40);
        chk("post_rst_cd", bus.cd, planar(rom(map_addr(18'h05555, 1'b1, 3'd4))));

        // Randomized traffic with settle checks.
        rca = bus.ca; rb = bus.bank; rs = bus.dec_sel;
        for (int it = 0; it < 200; it++) begin
            ack_delay = $urandom_range(0, 5);
            if ($urandom_range(0, 3) != 0) begin
                rca = 18'($urandom);
                rb  = 1'($urandom);
                rs  = 3'($urandom);
            end
            drive(rca, rb, rs);
            repeat ($urandom_range(1, 10)) @(negedge clk_main);
            if ($urandom_range(0, 3) == 0) begin
                repeat (2) @(negedge clk_main);
                wait_valid(80);
                chk("rnd_cd", bus.cd, planar(rom(map_addr(rca, rb, rs))));
            end
        end
        repeat (2) @(negedge clk_main);
        wait_valid(80);
        chk("rnd_stable", unstable, 0);
        chk("rnd_late_le_req", (int'(bus.late_cnt) <= reqs) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
